// File: rtl/riscv_bus_arbiter_if.sv
// riscv_bus_arbiter_if: one request/response bus link between a requester (master) and a responder (slave)
interface riscv_bus_arbiter_if;
  logic req;
  logic we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0] be;
  logic [31:0] rdata;
  logic ack;
  logic error;
  modport master (output req, we, addr, wdata, be, input rdata, ack, error);
  modport slave (input req, we, addr, wdata, be, output rdata, ack, error);
endinterface

// File: rtl/riscv_bus_arbiter.sv
// riscv_bus_arbiter: round-robin arbiter sharing one single-outstanding bus slave between two masters
module riscv_bus_arbiter #(
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rstn,
  riscv_bus_arbiter_if.slave m0,
  riscv_bus_arbiter_if.slave m1,
  riscv_bus_arbiter_if.master s,
  output logic grant
);
  localparam int W = $clog2(TIMEOUT + 1) < 1 ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state, state_n;
  logic [1:0] pend, pend_n, clr, fly;
  logic [W-1:0] cnt, cnt_n;
  logic grant_n, busy, resp, expire, done;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      pend <= 2'b00;
      cnt <= '0;
      grant <= 1'b1;
    end else begin
      state <= state_n;
      pend <= pend_n;
      cnt <= cnt_n;
      grant <= grant_n;
    end
  end
  always_comb begin
    busy = rstn && state != IDLE;
    resp = s.ack || s.error;
    expire = busy && state == WAIT && cnt == LIMIT && !resp;
    done = busy && (resp || expire);
    fly = busy && !done ? {grant, !grant} : 2'b00;
    state_n = state;
    grant_n = grant;
    cnt_n = cnt;
    clr = 2'b00;
    case (state)
      IDLE: if (|pend) begin
        grant_n = &pend ? !grant : pend[1];
        clr = grant_n ? 2'b10 : 2'b01;
        state_n = ISSUE;
      end
      ISSUE: begin
        cnt_n = '0;
        state_n = resp ? IDLE : WAIT;
      end
      default: begin
        cnt_n = &cnt ? cnt : cnt + 1'b1;
        state_n = resp || expire ? IDLE : WAIT;
      end
    endcase
    pend_n = (pend | ({m1.req, m0.req} & ~fly)) & ~clr;
  end
  assign s.req = busy && state == ISSUE;
  assign s.we = s.req && (grant ? m1.we : m0.we);
  assign s.addr = grant ? m1.addr : m0.addr;
  assign s.wdata = grant ? m1.wdata : m0.wdata;
  assign s.be = grant ? m1.be : m0.be;
  assign m0.ack = busy && !grant && s.ack;
  assign m0.error = busy && !grant && (s.error || expire);
  assign m0.rdata = busy && !grant ? s.rdata : '0;
  assign m1.ack = busy && grant && s.ack;
  assign m1.error = busy && grant && (s.error || expire);
  assign m1.rdata = busy && grant ? s.rdata : '0;
endmodule

// File: tb/tb_riscv_bus_arbiter.sv
// tb_riscv_bus_arbiter: vector table, reset corner sequence and randomized model check of riscv_bus_arbiter
module tb_riscv_bus_arbiter;
  localparam int TIMEOUT = 4;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic grant;
  int total = 0;
  int bad = 0;
  riscv_bus_arbiter_if m0();
  riscv_bus_arbiter_if m1();
  riscv_bus_arbiter_if s();
  riscv_bus_arbiter #(.TIMEOUT(TIMEOUT)) dut (.clk(clk), .rstn(rstn), .m0(m0), .m1(m1), .s(s), .grant(grant));
  always #5 clk = ~clk;
  typedef struct {
    logic [4:0] in;
    logic [31:0] rd;
    logic [6:0] x;
    logic [31:0] xr0;
    logic [31:0] xr1;
  } vec_t;
  vec_t v[29];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_bus(input string tag, input logic [6:0] x, input logic [31:0] xr0, input logic [31:0] xr1);
    chk({tag, " s_req"}, 32'(s.req), 32'(x[6]));
    chk({tag, " s_we"}, 32'(s.we), 32'(x[5]));
    chk({tag, " grant"}, 32'(grant), 32'(x[4]));
    chk({tag, " m0_ack"}, 32'(m0.ack), 32'(x[3]));
    chk({tag, " m0_err"}, 32'(m0.error), 32'(x[2]));
    chk({tag, " m1_ack"}, 32'(m1.ack), 32'(x[1]));
    chk({tag, " m1_err"}, 32'(m1.error), 32'(x[0]));
    chk({tag, " m0_rdata"}, m0.rdata, xr0);
    chk({tag, " m1_rdata"}, m1.rdata, xr1);
    chk({tag, " s_addr"}, s.addr, x[4] ? m1.addr : m0.addr);
    chk({tag, " s_wdata"}, s.wdata, x[4] ? m1.wdata : m0.wdata);
    chk({tag, " s_be"}, 32'(s.be), 32'(x[4] ? m1.be : m0.be));
  endtask
  int owner;
  int age;
  int last;
  int busy_m;
  int pick;
  logic [1:0] pend;
  logic [1:0] acc;
  logic act, resp, expire, done;
  initial begin
    v = '{
      '{5'b01000, 32'h0, 7'b0010000, 32'h0, 32'h0},
      '{5'b00000, 32'h0, 7'b0010000, 32'h0, 32'h0},
      '{5'b00000, 32'h0, 7'b1010000, 32'h0, 32'h0},
      '{5'b00010, 32'hDEADBEEF, 7'b0010010, 32'h0, 32'hDEADBEEF},
      '{5'b00000, 32'h0, 7'b0010000, 32'h0, 32'h0},
      '{5'b11000, 32'h0, 7'b0010000, 32'h0, 32'h0},
      '{5'b00000, 32'h0, 7'b0010000, 32'h0, 32'h0},
      '{5'b10010, 32'h12345678, 7'b1001000, 32'h12345678, 32'h0},
      '{5'b00000, 32'h0, 7'b0000000, 32'h0, 32'h0},
      '{5'b01010, 32'hCAFEF00D, 7'b1010010, 32'h0, 32'hCAFEF00D},
      '{5'b00000, 32'h0, 7'b0010000, 32'h0, 32'h0},
      '{5'b00010, 32'hA5A5A5A5, 7'b1001000, 32'hA5A5A5A5, 32'h0},
      '{5'b00000, 32'h0, 7'b0000000, 32'h0, 32'h0},
      '{5'b00000, 32'h0, 7'b1010000, 32'h0, 32'h0},
      '{5'b00001, 32'h0, 7'b0010001, 32'h0, 32'h0},
      '{5'b01100, 32'h0, 7'b0010000, 32'h0, 32'h0},
      '{5'b00100, 32'h0, 7'b0010000, 32'h0, 32'h0},
      '{5'b00100, 32'h0, 7'b1110000, 32'h0, 32'h0},
      '{5'b00110, 32'h00000055, 7'b0010010, 32'h0, 32'h00000055},
      '{5'b10000, 32'h0, 7'b0010000, 32'h0, 32'h0},
      '{5'b00000, 32'h0, 7'b0010000, 32'h0, 32'h0},
      '{5'b00000, 32'h0, 7'b1000000, 32'h0, 32'h0},
      '{5'b00000, 32'h0, 7'b0000000, 32'h0, 32'h0},
      '{5'b00000, 32'h0, 7'b0000000, 32'h0, 32'h0},
      '{5'b00000, 32'h0, 7'b0000000, 32'h0, 32'h0},
      '{5'b00000, 32'h0, 7'b0000000, 32'h0, 32'h0},
      '{5'b00000, 32'h0, 7'b0000100, 32'h0, 32'h0},
      '{5'b00010, 32'h00000077, 7'b0000000, 32'h0, 32'h0},
      '{5'b00001, 32'h0, 7'b0000000, 32'h0, 32'h0}
    };
    m0.req = 1'b0; m0.we = 1'b0; m0.addr = 32'h00000100; m0.wdata = 32'h11111111; m0.be = 4'hF;
    m1.req = 1'b0; m1.we = 1'b0; m1.addr = 32'h00001004; m1.wdata = 32'h00AB0000; m1.be = 4'b0100;
    s.ack = 1'b1; s.error = 1'b0; s.rdata = 32'hFFFF0000;
    rstn = 1'b0;
    repeat (2) cyc();
    chk_bus("reset", 7'b0010000, 32'h0, 32'h0);
    s.ack = 1'b0;
    rstn = 1'b1;
    for (int i = 0; i < 29; i++) begin
      {m0.req, m1.req, m1.we, s.ack, s.error} = v[i].in;
      s.rdata = v[i].rd;
      #2;
      chk_bus($sformatf("vec%0d", i), v[i].x, v[i].xr0, v[i].xr1);
      cyc();
    end
    {m0.req, m1.req, m1.we, s.ack, s.error} = 5'b10000;
    s.rdata = 32'h0;
    cyc();
    m0.req = 1'b0;
    cyc();
    m1.req = 1'b1;
    #2 chk_bus("rst_issue", 7'b1000000, 32'h0, 32'h0);
    cyc();
    m1.req = 1'b0;
    rstn = 1'b0;
    s.ack = 1'b1;
    s.rdata = 32'hBAD0BAD0;
    #2 chk_bus("rst_wait", 7'b0000000, 32'h0, 32'h0);
    cyc();
    rstn = 1'b1;
    #2 chk_bus("rst_late_ack", 7'b0010000, 32'h0, 32'h0);
    cyc();
    s.ack = 1'b0;
    #2 chk_bus("rst_idle", 7'b0010000, 32'h0, 32'h0);
    cyc();
    m1.req = 1'b1;
    #2 chk_bus("rst_nopend", 7'b0010000, 32'h0, 32'h0);
    cyc();
    m1.req = 1'b0;
    #2 chk_bus("rst_pend", 7'b0010000, 32'h0, 32'h0);
    cyc();
    s.ack = 1'b1;
    s.rdata = 32'h13579BDF;
    #2 chk_bus("rst_next", 7'b1010010, 32'h0, 32'h13579BDF);
    cyc();
    s.ack = 1'b0;
    owner = -1;
    age = 0;
    last = 1;
    pend = 2'b00;
    for (int c = 0; c < 3000; c++) begin
      rstn = c < 2 ? 1'b0 : $urandom_range(0, 99) != 0;
      m0.req = $urandom_range(0, 4) == 0;
      m1.req = $urandom_range(0, 4) == 0;
      m0.we = 1'($urandom);
      m1.we = 1'($urandom);
      m0.addr = $urandom;
      m1.addr = $urandom;
      m0.wdata = $urandom;
      m1.wdata = $urandom;
      m0.be = 4'($urandom);
      m1.be = 4'($urandom);
      s.ack = $urandom_range(0, 3) == 0;
      s.error = !s.ack && $urandom_range(0, 15) == 0;
      s.rdata = $urandom;
      #2;
      act = rstn && owner >= 0;
      resp = s.ack || s.error;
      expire = act && age == TIMEOUT + 1 && !resp;
      chk_bus($sformatf("rnd%0d", c),
        {act && age == 0, act && age == 0 && (last == 1 ? m1.we : m0.we), last == 1,
         act && owner == 0 && s.ack, act && owner == 0 && (s.error || expire),
         act && owner == 1 && s.ack, act && owner == 1 && (s.error || expire)},
        act && owner == 0 ? s.rdata : 32'h0, act && owner == 1 ? s.rdata : 32'h0);
      if (!rstn) begin
        owner = -1;
        age = 0;
        last = 1;
        pend = 2'b00;
      end else begin
        done = act && (resp || expire);
        busy_m = act && !done ? owner : -1;
        acc[0] = m0.req && !pend[0] && busy_m != 0;
        acc[1] = m1.req && !pend[1] && busy_m != 1;
        if (act) begin
          if (done) owner = -1;
          else age++;
        end else if (pend != 2'b00) begin
          pick = pend == 2'b11 ? 1 - last : (pend[0] ? 0 : 1);
          last = pick;
          owner = pick;
          age = 0;
          pend[pick] = 1'b0;
        end
        pend = pend | acc;
      end
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
